cache_l1: RTL and testbench



---
 rtl/cache_l1_pkg.sv | 32 +++
 rtl/cache_l1_store.sv | 48 ++++
 rtl/cache_l1.sv | 139 +++++++++++++
 tb/tb_cache_l1.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cache_l1_pkg.sv
// Shared types and address-field helpers for the direct-mapped L1 cache.
// Field widths follow the default geometry (8 lines x 4 words, 32-bit address).
package cache_l1_pkg;

    localparam int NUM_LINES_DEF      = 8;
    localparam int WORDS_PER_LINE_DEF = 4;
    localparam int ADDR_W_DEF         = 32;

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE_DEF);
    localparam int INDEX_W  = $clog2(NUM_LINES_DEF);
    localparam int TAG_W    = ADDR_W_DEF - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W_DEF-1:0] a);
        return a[OFFSET_W+1:2];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W_DEF-1:0] a);
        return a[INDEX_W+OFFSET_W+1:OFFSET_W+2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W_DEF-1:0] a);
        return a[ADDR_W_DEF-1:INDEX_W+OFFSET_W+2];
    endfunction

endpackage

// File: rtl/cache_l1_store.sv
// Valid/tag/data arrays: one asynchronous read port, one synchronous word write port.
// Valid bits clear on synchronous reset; data and tags are never reset.
module cache_l1_store
    import cache_l1_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_W         = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  i_rd_index,
    input  logic [OFFSET_W-1:0] i_rd_offset,
    output logic                o_rd_valid,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_wr_en,
    input  logic [INDEX_W-1:0]  i_wr_index,
    input  logic [OFFSET_W-1:0] i_wr_offset,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_inval,
    input  logic                i_tag_we,
    input  logic [TAG_W-1:0]    i_tag
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [DATA_W-1:0]    r_data [NUM_LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_inval)  r_valid[i_wr_index] <= 1'b0;
            if (i_tag_we) r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_we) r_tag[i_wr_index] <= i_tag;
        if (i_wr_en)  r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];

endmodule

// File: rtl/cache_l1.sv
// Direct-mapped write-through, no-write-allocate L1: zero-wait read hits,
// WORDS_PER_LINE-cycle line fill on read miss, one memory cycle per write.
module cache_l1
    import cache_l1_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_DEF,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    inout  wire  [DATA_W-1:0] cpu_data,
    output logic              cpu_hold,
    output logic              mem_ce,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              last_access_hit
);

    state_t              r_state, w_next;
    logic [OFFSET_W-1:0] r_cnt;
    logic [ADDR_W-1:0]   r_base, r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_last_hit;

    logic                w_rd_valid, w_hit, w_last_word, w_cpu_drv, w_mem_drv;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [DATA_W-1:0]   w_rd_data, w_wr_data;
    logic                w_st_we, w_inval, w_tag_we;
    logic [INDEX_W-1:0]  w_wr_index;
    logic [OFFSET_W-1:0] w_wr_offset;

    assign w_hit       = w_rd_valid && (w_rd_tag == addr_tag(cpu_addr));
    assign w_last_word = (r_cnt == OFFSET_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (cpu_ce) w_next = cpu_rw ? (w_hit ? IDLE : FILL) : WRITE;
            FILL:  if (w_last_word) w_next = IDLE;
            WRITE: w_next = WDONE;
            WDONE: if (!cpu_ce) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_hold  = 1'b0;
        mem_ce    = 1'b0;
        mem_rw    = 1'b1;
        mem_addr  = '0;
        w_cpu_drv = 1'b0;
        w_mem_drv = 1'b0;
        case (r_state)
            IDLE: begin
                w_cpu_drv = cpu_ce && cpu_rw && w_hit;
                cpu_hold  = cpu_ce && !(cpu_rw && w_hit);
            end
            FILL: begin
                cpu_hold = 1'b1;
                mem_ce   = 1'b1;
                mem_addr = r_base + ADDR_W'({r_cnt, 2'b00});
            end
            WRITE: begin
                cpu_hold  = 1'b1;
                mem_ce    = 1'b1;
                mem_rw    = 1'b0;
                mem_addr  = {r_waddr[ADDR_W-1:2], 2'b00};
                w_mem_drv = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_base     <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_last_hit <= 1'b0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
            if (cpu_ce) begin
                r_last_hit <= w_hit;
                r_base     <= cpu_addr & ~ADDR_W'(WORDS_PER_LINE * 4 - 1);
                r_waddr    <= cpu_addr;
                r_wdata    <= cpu_data;
            end
        end else if (r_state == FILL) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Line is invalidated as the fill starts so a partially refilled line can never hit.
    assign w_inval     = (r_state == IDLE) && cpu_ce && cpu_rw && !w_hit;
    assign w_tag_we    = (r_state == FILL) && w_last_word;
    assign w_st_we     = (r_state == FILL) || ((r_state == WRITE) && w_hit);
    assign w_wr_index  = (r_state == FILL)  ? addr_index(r_base)  :
                         (r_state == WRITE) ? addr_index(r_waddr) : addr_index(cpu_addr);
    assign w_wr_offset = (r_state == FILL) ? r_cnt : addr_offset(r_waddr);
    assign w_wr_data   = (r_state == FILL) ? mem_data : r_wdata;

    cache_l1_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_W         (DATA_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (addr_index(cpu_addr)),
        .i_rd_offset (addr_offset(cpu_addr)),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_st_we),
        .i_wr_index  (w_wr_index),
        .i_wr_offset (w_wr_offset),
        .i_wr_data   (w_wr_data),
        .i_inval     (w_inval),
        .i_tag_we    (w_tag_we),
        .i_tag       (addr_tag(r_base))
    );

    assign cpu_data        = w_cpu_drv ? w_rd_data : 'z;
    assign mem_data        = w_mem_drv ? r_wdata   : 'z;
    assign last_access_hit = r_last_hit;

endmodule

// File: tb/tb_cache_l1.sv
// Scoreboarded bench for cache_l1: directed plan, mid-fill reset, then random traffic.
module tb_cache_l1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce, cpu_rw;
    logic [31:0] cpu_addr;
    wire  [31:0] cpu_data, mem_data;
    logic        cpu_hold, mem_ce, mem_rw, last_access_hit;
    logic [31:0] mem_addr;

    logic        tb_drv;
    logic [31:0] tb_wdat;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    bit          m_valid [8];
    logic [24:0] m_tag   [8];
    logic [31:0] sb_q[$];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    cache_l1 dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_ce          (cpu_ce),
        .cpu_rw          (cpu_rw),
        .cpu_addr        (cpu_addr),
        .cpu_data        (cpu_data),
        .cpu_hold        (cpu_hold),
        .mem_ce          (mem_ce),
        .mem_rw          (mem_rw),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .last_access_hit (last_access_hit)
    );

    assign cpu_data = tb_drv ? tb_wdat : 'z;
    assign mem_data = (mem_ce === 1'b1 && mem_rw === 1'b1) ? mem[mem_addr[9:2]] : 'z;

    always @(posedge clk)
        if (mem_ce === 1'b1 && mem_rw === 1'b0) mem[mem_addr[9:2]] <= mem_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_hold",     cpu_hold, 0);
        chk("rst_mem_ce",   mem_ce, 0);
        chk("rst_mem_rw",   mem_rw, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_data", cpu_data, 'z);
        chk("rst_mem_data", mem_data, 'z);
        chk("rst_last_hit", last_access_hit, 0);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic do_read(input logic [31:0] addr);
        int idx, k;
        bit miss;
        logic [31:0] base;
        idx  = int'(addr[6:4]);
        miss = !(m_valid[idx] && m_tag[idx] == addr[31:7]);
        base = addr & 32'hFFFF_FFF0;
        sb_q.push_back(ref_mem[addr[9:2]]);
        cpu_ce = 1'b1; cpu_rw = 1'b1; cpu_addr = addr;
        #1;
        chk("rd_hold_now", cpu_hold, miss);
        chk("rd_memce_now", mem_ce, 0);
        k = 0;
        while (cpu_hold === 1'b1 && k < 20) begin
            @(posedge clk); #1;
            if (cpu_hold === 1'b1) begin
                if (k < 4) begin
                    chk("fill_addr", mem_addr, base + 32'(4 * k));
                    chk("fill_rw", mem_rw, 1);
                end
                k++;
            end
        end
        chk("rd_stall_cycles", k, miss ? 4 : 0);
        chk("rd_data", cpu_data, sb_q.pop_front());
        @(posedge clk); #1;
        chk("rd_last_hit", last_access_hit, 1);
        cpu_ce = 1'b0;
        if (miss) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[31:7];
        end
        @(posedge clk); #1;
        chk("idle_last_hit_holds", last_access_hit, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int idx;
        bit hit;
        idx = int'(addr[6:4]);
        hit = m_valid[idx] && m_tag[idx] == addr[31:7];
        cpu_ce = 1'b1; cpu_rw = 1'b0; cpu_addr = addr; tb_wdat = data; tb_drv = 1'b1;
        #1;
        chk("wr_hold_now", cpu_hold, 1);
        @(posedge clk); #1;
        tb_drv = 1'b0;
        chk("wr_mem_ce", mem_ce, 1);
        chk("wr_mem_rw", mem_rw, 0);
        chk("wr_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("wr_mem_data", mem_data, data);
        chk("wr_last_hit", last_access_hit, hit);
        ref_mem[addr[9:2]] = data;
        @(posedge clk); #1;
        chk("wdone_hold", cpu_hold, 0);
        chk("wr_mem_commit", mem[addr[9:2]], data);
        @(posedge clk); #1;
        chk("wdone_no_repeat", mem_ce, 0);
        cpu_ce = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tb_drv = 1'b0; tb_wdat = '0;
        cpu_ce = 1'b0; cpu_rw = 1'b1; cpu_addr = '0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        do_read(32'h20);   // cold miss
        do_read(32'h20);   // hit
        do_read(32'h2C);   // same-line hit
        do_read(32'hA0);   // conflict miss
        do_read(32'h20);   // evicted, misses again
        do_write(32'h24, 32'hDEAD_BEEF);
        do_read(32'h24);
        do_write(32'h100, 32'h0BAD_CAFE);
        do_read(32'h100);

        // Reset in the middle of a fill.
        cpu_ce = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midfill_addr", mem_addr, 32'h44);
        rst = 1'b1; cpu_ce = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs();
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        do_read(32'h40);
        do_read(32'h20);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 2) == 0) do_write(a, $urandom);
            else                           do_read(a);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
